// File: rtl/serial_tx.sv
// 8N1 UART-style transmitter, MSB-first, paced by an external baud tick (tx_clk).
// Define SERIAL_TX_FIFO_EN for a FIFO_DEPTH-entry input FIFO; otherwise a single holding register is used.
module serial_tx #(
    parameter int unsigned OVERSAMPLE = 8,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_clk,
    input  logic [7:0] data_out,
    input  logic       new_data_out,
    output logic       ready,
    output logic       tx,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    localparam logic [2:0] TICK_LAST = 3'(OVERSAMPLE - 1);
    localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

    state_t     state, state_next;
    logic [2:0] tick_cnt, tick_cnt_next;
    logic [2:0] bit_cnt, bit_cnt_next;
    logic [7:0] shift, shift_next;
    logic       tx_next;
    logic       pop;
    logic       pending;
    logic       accept;
    logic [7:0] head;

    assign accept = new_data_out && ready;

`ifdef SERIAL_TX_FIFO_EN
    // Pointers carry one extra bit so full and empty are distinguishable; FIFO_DEPTH >= 2.
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_FILL = (AW + 1)'(FIFO_DEPTH);

    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic [AW:0] fill;

    assign fill    = wr_ptr - rd_ptr;
    assign ready   = (fill != FULL_FILL);
    assign pending = (fill != '0);
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (accept) begin
                mem[wr_ptr[AW-1:0]] <= data_out;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end
`else
    logic       hold_valid;
    logic [7:0] hold_data;

    assign ready   = !hold_valid;
    assign pending = hold_valid;
    assign head    = hold_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid <= 1'b0;
            hold_data  <= '0;
        end else if (accept) begin
            hold_valid <= 1'b1;
            hold_data  <= data_out;
        end else if (pop) begin
            hold_valid <= 1'b0;
        end
    end
`endif

    assign busy = (state != IDLE) || pending;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            tx       <= 1'b1;
        end else begin
            state    <= state_next;
            tick_cnt <= tick_cnt_next;
            bit_cnt  <= bit_cnt_next;
            shift    <= shift_next;
            tx       <= tx_next;
        end
    end

    always_comb begin
        state_next    = state;
        tick_cnt_next = tick_cnt;
        bit_cnt_next  = bit_cnt;
        shift_next    = shift;
        tx_next       = tx;
        pop           = 1'b0;
        if (tx_clk) begin
            unique case (state)
                IDLE: begin
                    tx_next = 1'b1;
                    if (pending) begin
                        pop           = 1'b1;
                        shift_next    = head;
                        tx_next       = 1'b0;
                        tick_cnt_next = '0;
                        state_next    = START;
                    end
                end
                START: begin
                    if (tick_cnt == TICK_LAST) begin
                        tick_cnt_next = '0;
                        bit_cnt_next  = '0;
                        tx_next       = shift[7];
                        state_next    = DATA;
                    end else begin
                        tick_cnt_next = tick_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (tick_cnt == TICK_LAST) begin
                        tick_cnt_next = '0;
                        if (bit_cnt == 3'd7) begin
                            tx_next      = 1'b1;
                            bit_cnt_next = '0;
                            state_next   = STOP;
                        end else begin
                            shift_next   = {shift[6:0], 1'b0};
                            tx_next      = shift[6];
                            bit_cnt_next = bit_cnt + 1'b1;
                        end
                    end else begin
                        tick_cnt_next = tick_cnt + 1'b1;
                    end
                end
                STOP: begin
                    // bit_cnt is reused to count stop bits; a pending byte starts with no idle gap.
                    if (tick_cnt == TICK_LAST) begin
                        tick_cnt_next = '0;
                        if (bit_cnt == STOP_LAST) begin
                            bit_cnt_next = '0;
                            if (pending) begin
                                pop        = 1'b1;
                                shift_next = head;
                                tx_next    = 1'b0;
                                state_next = START;
                            end else begin
                                state_next = IDLE;
                            end
                        end else begin
                            bit_cnt_next = bit_cnt + 1'b1;
                        end
                    end else begin
                        tick_cnt_next = tick_cnt + 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: default instance plus a STOP_BITS=2 instance, tick every DIV clocks,
// bytes pushed to a scoreboard on accept and checked by a tick-sampling line decoder.
module tb_serial_tx;

    localparam int DIV = 13;
    localparam int OS  = 8;
`ifdef SERIAL_TX_FIFO_EN
    localparam int OUTSTANDING = 5;
`else
    localparam int OUTSTANDING = 2;
`endif

    logic       clk, rst, tx_clk;
    logic [7:0] data_out, d2;
    logic       new_data_out, nd2;
    logic       ready, tx, busy;
    logic       ready2, tx2, busy2;

    serial_tx dut (
        .clk(clk), .rst(rst), .tx_clk(tx_clk), .data_out(data_out),
        .new_data_out(new_data_out), .ready(ready), .tx(tx), .busy(busy)
    );

    serial_tx #(.STOP_BITS(2)) dut2 (
        .clk(clk), .rst(rst), .tx_clk(tx_clk), .data_out(d2),
        .new_data_out(nd2), .ready(ready2), .tx(tx2), .busy(busy2)
    );

    int checks = 0;
    int failures = 0;

    logic [7:0] sbq0[$];
    logic [7:0] sbq1[$];

    int         tick_no = 0;
    int         idx [2] = '{-1, -1};
    int         start_tick [2] = '{0, 0};
    int         end_tick [2] = '{-10, -10};
    int         frames_started [2] = '{0, 0};
    int         frames_done [2] = '{0, 0};
    int         contig [2] = '{0, 0};
    int         bad [2] = '{0, 0};
    int         accepts [2] = '{0, 0};
    logic [7:0] got [2];
    logic [7:0] expb [2];
    logic       last_acc;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        tx_clk = 1'b0;
        forever begin
            repeat (DIV - 1) @(negedge clk);
            tx_clk = 1'b1;
            @(negedge clk);
            tx_clk = 1'b0;
        end
    end

    task automatic mon_tick(input int d, input logic b);
        int   k;
        logic e;
        if (idx[d] < 0 && b == 1'b0) begin
            idx[d] = 0;
            start_tick[d] = tick_no;
            frames_started[d]++;
            if (start_tick[d] == end_tick[d] + 1) contig[d]++;
            bad[d] = 0;
            got[d] = '0;
            if ((d == 0 ? sbq0.size() : sbq1.size()) == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_frame dut=%0d got=frame expected=no frame", d);
                expb[d] = '0;
            end else if (d == 0) begin
                expb[d] = sbq0.pop_front();
            end else begin
                expb[d] = sbq1.pop_front();
            end
        end
        if (idx[d] >= 0) begin
            k = idx[d] / OS;
            if (k == 0) e = 1'b0;
            else if (k <= 8) e = expb[d][3'(8 - k)];
            else e = 1'b1;
            if (b !== e) bad[d]++;
            if ((idx[d] % OS) == OS / 2 && k >= 1 && k <= 8) got[d] = {got[d][6:0], b};
            if (idx[d] == (d == 0 ? 10 * OS : 11 * OS) - 1) begin
                checks++;
                if (got[d] !== expb[d]) begin
                    failures++;
                    $display("FAIL frame_byte dut=%0d got=%02h expected=%02h", d, got[d], expb[d]);
                end
                checks++;
                if (bad[d] != 0) begin
                    failures++;
                    $display("FAIL frame_shape dut=%0d byte=%02h got=%0d bad ticks expected=0", d, expb[d], bad[d]);
                end
                frames_done[d]++;
                end_tick[d] = tick_no;
                idx[d] = -1;
            end else begin
                idx[d]++;
            end
        end
    endtask

    always @(posedge clk) begin
        logic tk, rs;
        tk = tx_clk;
        rs = rst;
        #1;
        if (tk) tick_no++;
        if (rs) begin
            idx[0] = -1;
            idx[1] = -1;
        end else if (tk) begin
            mon_tick(0, tx);
            mon_tick(1, tx2);
        end
    end

    task automatic cycle(input int d, input logic v, input logic [7:0] b);
        @(negedge clk);
        #1;
        if (d == 0) begin
            new_data_out = v;
            data_out = b;
        end else begin
            nd2 = v;
            d2 = b;
        end
        last_acc = v && !rst && (d == 0 ? ready : ready2);
        if (last_acc) begin
            accepts[d]++;
            if (d == 0) sbq0.push_back(b);
            else sbq1.push_back(b);
        end
        @(posedge clk);
    endtask

    task automatic send(input int d, input logic [7:0] b);
        int n = 0;
        last_acc = 1'b0;
        while (!last_acc && n < 3000) begin
            cycle(d, 1'b1, b);
            n++;
        end
        checks++;
        if (!last_acc) begin
            failures++;
            $display("FAIL send_timeout dut=%0d byte=%02h got=not accepted expected=accepted", d, b);
        end
    endtask

    task automatic wait_idle(input int d);
        int n = 0;
        bit done = 0;
        while (!done && n < 9000) begin
            @(posedge clk);
            #2;
            done = !(d == 0 ? busy : busy2) && idx[d] < 0 &&
                   (d == 0 ? sbq0.size() : sbq1.size()) == 0;
            n++;
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL idle_timeout dut=%0d got=busy expected=idle", d);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        checks += 6;
        if (tx !== 1'b1)     begin failures++; $display("FAIL reset_tx got=%b expected=1", tx); end
        if (ready !== 1'b1)  begin failures++; $display("FAIL reset_ready got=%b expected=1", ready); end
        if (busy !== 1'b0)   begin failures++; $display("FAIL reset_busy got=%b expected=0", busy); end
        if (tx2 !== 1'b1)    begin failures++; $display("FAIL reset_tx2 got=%b expected=1", tx2); end
        if (ready2 !== 1'b1) begin failures++; $display("FAIL reset_ready2 got=%b expected=1", ready2); end
        if (busy2 !== 1'b0)  begin failures++; $display("FAIL reset_busy2 got=%b expected=0", busy2); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Accept lands on a tick edge; that tick must not start the frame.
    task automatic test_single();
        int acc_tick, fs, n;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!tx_clk && n < 40);
        new_data_out = 1'b1;
        data_out = 8'hA5;
        sbq0.push_back(8'hA5);
        accepts[0]++;
        fs = frames_started[0];
        @(posedge clk);
        #2;
        acc_tick = tick_no;
        @(negedge clk);
        new_data_out = 1'b0;
        n = 0;
        while (frames_started[0] == fs && n < 200) begin
            @(posedge clk);
            #2;
            n++;
        end
        checks++;
        if (start_tick[0] != acc_tick + 1 || frames_started[0] == fs) begin
            failures++;
            $display("FAIL start_latency got=%0d ticks expected=1", start_tick[0] - acc_tick);
        end
        n = 0;
        while (busy && n < 3000) begin
            @(posedge clk);
            #2;
            n++;
        end
        checks++;
        if (tick_no - start_tick[0] != 80) begin
            failures++;
            $display("FAIL busy_len got=%0d ticks expected=80", tick_no - start_tick[0]);
        end
        wait_idle(0);
    endtask

    task automatic test_loopback();
        logic [7:0] bytes [4] = '{8'h00, 8'hFF, 8'h5A, 8'h81};
        int fd;
        for (int i = 0; i < 4; i++) begin
            fd = frames_done[0];
            send(0, bytes[i]);
            cycle(0, 1'b0, 8'h00);
            wait_idle(0);
            checks++;
            if (frames_done[0] != fd + 1) begin
                failures++;
                $display("FAIL loop_frames byte=%02h got=%0d expected=1", bytes[i], frames_done[0] - fd);
            end
        end
    endtask

    task automatic test_back_to_back();
        int fd0, ct0, n;
        fd0 = frames_done[0];
        ct0 = contig[0];
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!tx_clk && n < 40);
        repeat (DIV - 2) @(posedge clk);
        for (int i = 0; i < OUTSTANDING; i++) send(0, 8'(8'h30 + i));
        @(negedge clk);
        #1;
        checks++;
        if (ready !== 1'b0) begin
            failures++;
            $display("FAIL b2b_full_ready got=%b expected=0", ready);
        end
        send(0, 8'(8'h30 + OUTSTANDING));
        checks++;
        if (frames_done[0] - fd0 != 1) begin
            failures++;
            $display("FAIL b2b_last_accept got=%0d frames done expected=1", frames_done[0] - fd0);
        end
        cycle(0, 1'b0, 8'h00);
        wait_idle(0);
        checks += 2;
        if (frames_done[0] - fd0 != OUTSTANDING + 1) begin
            failures++;
            $display("FAIL b2b_frames got=%0d expected=%0d", frames_done[0] - fd0, OUTSTANDING + 1);
        end
        if (contig[0] - ct0 != OUTSTANDING) begin
            failures++;
            $display("FAIL b2b_contiguous got=%0d expected=%0d", contig[0] - ct0, OUTSTANDING);
        end
    endtask

    task automatic test_reset_midframe();
        int n, fs;
        send(0, 8'h3C);
        send(0, 8'h77);
        cycle(0, 1'b0, 8'h00);
        n = 0;
        while (idx[0] < OS + 3 * OS && n < 3000) begin
            @(posedge clk);
            #2;
            n++;
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #2;
        checks += 3;
        if (tx !== 1'b1)    begin failures++; $display("FAIL midrst_tx got=%b expected=1", tx); end
        if (busy !== 1'b0)  begin failures++; $display("FAIL midrst_busy got=%b expected=0", busy); end
        if (ready !== 1'b1) begin failures++; $display("FAIL midrst_ready got=%b expected=1", ready); end
        sbq0.delete();
        @(negedge clk);
        rst = 1'b0;
        fs = frames_started[0];
        repeat (1500) @(posedge clk);
        #2;
        checks++;
        if (frames_started[0] != fs || tx !== 1'b1) begin
            failures++;
            $display("FAIL midrst_quiet got=%0d frames expected=0", frames_started[0] - fs);
        end
        fs = frames_done[0];
        send(0, 8'h11);
        cycle(0, 1'b0, 8'h00);
        wait_idle(0);
        checks++;
        if (frames_done[0] != fs + 1) begin
            failures++;
            $display("FAIL midrst_recover got=%0d frames expected=1", frames_done[0] - fs);
        end
    endtask

    task automatic test_hold_valid();
        int a0, f0;
        a0 = accepts[0];
        f0 = frames_done[0];
        send(0, 8'h40);
        for (int i = 0; i < 200; i++) cycle(0, 1'b1, 8'(8'h41 + i));
        cycle(0, 1'b0, 8'h00);
        checks++;
        if (accepts[0] - a0 != OUTSTANDING) begin
            failures++;
            $display("FAIL hold_accepts got=%0d expected=%0d", accepts[0] - a0, OUTSTANDING);
        end
        wait_idle(0);
        checks++;
        if (frames_done[0] - f0 != accepts[0] - a0) begin
            failures++;
            $display("FAIL hold_frames got=%0d expected=%0d", frames_done[0] - f0, accepts[0] - a0);
        end
    endtask

    task automatic test_stop2();
        int fs, viol, n;
        fs = frames_started[1];
        viol = 0;
        send(1, 8'hC3);
        n = 0;
        while (n < 100) begin
            @(negedge clk);
            #1;
            nd2 = 1'b0;
            if (frames_started[1] != fs) break;
            if (ready2 !== 1'b0) viol++;
            n++;
        end
        checks += 2;
        if (viol != 0 || frames_started[1] == fs) begin
            failures++;
            $display("FAIL stop2_ready_low got=%0d violations expected=0", viol);
        end
        if (ready2 !== 1'b1) begin
            failures++;
            $display("FAIL stop2_ready_start got=%b expected=1", ready2);
        end
        n = 0;
        while (busy2 && n < 3000) begin
            @(posedge clk);
            #2;
            n++;
        end
        checks++;
        if (tick_no - start_tick[1] != 88) begin
            failures++;
            $display("FAIL stop2_len got=%0d ticks expected=88", tick_no - start_tick[1]);
        end
        wait_idle(1);
    endtask

    initial begin
        rst = 1'b1;
        new_data_out = 1'b0;
        data_out = '0;
        nd2 = 1'b0;
        d2 = '0;
        last_acc = 1'b0;
        test_reset();
        test_single();
        test_loopback();
        test_back_to_back();
        test_reset_midframe();
        test_hold_valid();
        test_stop2();
        repeat (20) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
